ov7670_sccb_sequencer: RTL and testbench

//  Power-up and register-configuration sequencer for the OV7670 CMOS sensor.

---
 rtl/ov7670_sccb_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_ov7670_sccb_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_sequencer.sv
// OV7670 power-up sequencer and SCCB register-table loader.
// Walks a synchronous ROM and issues one SCCB write per entry.
module ov7670_sccb_sequencer #(
  parameter int         MS_TICKS   = 50000,
  parameter int         PWDN_MS    = 1,
  parameter int         RST_MS     = 1,
  parameter int         PWRUP_MS   = 10,
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         ADDR_W     = 8,
  parameter int         MAX_RETRY  = 3,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_req,
  output logic [7:0]        sccb_dev,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_val,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              cmos_pwdn,
  output logic              cmos_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        err_count
);

  localparam int TW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(MS_TICKS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_PWDN, S_RST, S_PWRUP, S_FETCH,
    S_DECODE, S_WRITE, S_DELAY, S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [15:0]       ms_q, ms_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        val_q, val_d;
  logic [7:0]        dly_q, dly_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [7:0]        err_q, err_d;
  logic              pwdn_q, pwdn_d;
  logic              rstn_q, rstn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              auto_q, auto_d;

  logic              timed;
  logic              hit;
  logic [15:0]       target;
  logic              next_entry;

  // Timed states count whole milliseconds; the counters idle at zero elsewhere.
  always_comb begin
    timed  = 1'b1;
    target = 16'd0;
    unique case (state_q)
      S_PWDN:  target = 16'(PWDN_MS);
      S_RST:   target = 16'(RST_MS);
      S_PWRUP: target = 16'(PWRUP_MS);
      S_DELAY: target = {8'd0, dly_q};
      default: timed  = 1'b0;
    endcase
    hit = timed && ((target == 16'd0) ||
          (tick_q == TICK_LAST && ms_q == target - 16'd1));
  end

  always_comb begin
    tick_d = '0;
    ms_d   = '0;
    if (timed && !hit) begin
      if (tick_q == TICK_LAST) begin
        ms_d = ms_q + 16'd1;
      end else begin
        tick_d = tick_q + TW'(1);
        ms_d   = ms_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_d      = req_q;
    reg_d      = reg_q;
    val_d      = val_q;
    dly_d      = dly_q;
    retry_d    = retry_q;
    err_d      = err_q;
    pwdn_d     = pwdn_q;
    rstn_d     = rstn_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    auto_d     = auto_q;
    next_entry = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          auto_d  = 1'b0;
          done_d  = 1'b0;
          error_d = 1'b0;
          err_d   = 8'd0;
          addr_d  = '0;
          busy_d  = 1'b1;
          pwdn_d  = 1'b1;
          rstn_d  = 1'b0;
          state_d = S_PWDN;
        end
      end
      S_PWDN: begin
        if (hit) begin
          pwdn_d  = 1'b0;
          state_d = S_RST;
        end
      end
      S_RST: begin
        if (hit) begin
          rstn_d  = 1'b1;
          state_d = S_PWRUP;
        end
      end
      S_PWRUP: begin
        if (hit) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          rom_data[15:8] == 8'hFE: state_d = S_FINISH;
          rom_data[15:8] == 8'hFF: begin
            dly_d = rom_data[7:0];
            if (rom_data[7:0] == 8'd0) next_entry = 1'b1;
            else                       state_d    = S_DELAY;
          end
          default: begin
            reg_d   = rom_data[15:8];
            val_d   = rom_data[7:0];
            retry_d = '0;
            req_d   = 1'b1;
            state_d = S_WRITE;
          end
        endcase
      end
      S_WRITE: begin
        // req low inside WRITE is the single idle cycle before a retry.
        if (!req_q) begin
          req_d = 1'b1;
        end else if (sccb_done) begin
          req_d = 1'b0;
          if (!sccb_nack) begin
            next_entry = 1'b1;
          end else if (retry_q != RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
          end else begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            next_entry = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (hit) next_entry = 1'b1;
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        error_d = (err_q != 8'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (next_entry) begin
      if (addr_q == ADDR_LAST) begin
        state_d = S_FINISH;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      ms_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      reg_q   <= 8'd0;
      val_q   <= 8'd0;
      dly_q   <= 8'd0;
      retry_q <= '0;
      err_q   <= 8'd0;
      pwdn_q  <= 1'b1;
      rstn_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      dly_q   <= dly_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      pwdn_q  <= pwdn_d;
      rstn_q  <= rstn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      auto_q  <= auto_d;
    end
  end

  assign rom_addr   = addr_q;
  assign sccb_req   = req_q;
  assign sccb_dev   = DEV_ADDR;
  assign sccb_reg   = reg_q;
  assign sccb_val   = val_q;
  assign cmos_pwdn  = pwdn_q;
  assign cmos_rst_n = rstn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_ov7670_sccb_sequencer.sv
// Bench for ov7670_sccb_sequencer: ROM + SCCB master models,
// table-walk reference model, directed and random runs.
module tb_ov7670_sccb_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  rom_addr;
  logic [15:0] rom_data = 16'd0;
  logic        sccb_req;
  logic [7:0]  sccb_dev, sccb_reg, sccb_val;
  logic        sccb_done = 1'b0;
  logic        sccb_nack = 1'b0;
  logic        cmos_pwdn, cmos_rst_n, busy, done, error;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  ov7670_sccb_sequencer #(
    .MS_TICKS(10), .PWDN_MS(1), .RST_MS(1), .PWRUP_MS(2),
    .DEV_ADDR(8'h42), .ADDR_W(3), .MAX_RETRY(3), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_req(sccb_req), .sccb_dev(sccb_dev),
    .sccb_reg(sccb_reg), .sccb_val(sccb_val),
    .sccb_done(sccb_done), .sccb_nack(sccb_nack),
    .cmos_pwdn(cmos_pwdn), .cmos_rst_n(cmos_rst_n),
    .busy(busy), .done(done), .error(error),
    .err_count(err_count)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] rom [8];
  int          nk  [8];
  int          att [8];
  int          lat = 5;
  int          stab_err = 0;
  logic [31:0] log_q [$];
  logic [31:0] exp_q [$];
  int          exp_err;
  int          exp_addr;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rom_data = rom[rom_addr];
    end
  end

  // SCCB master: acks after lat cycles, NACKs the first nk[a] attempts.
  initial begin : master
    int         cnt;
    bit         pend;
    logic [7:0] s_reg, s_val;
    logic [2:0] s_a;
    logic       nak;
    pend = 0;
    cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      if (!reset_n) begin
        pend = 0;
        for (int i = 0; i < 8; i++) att[i] = 0;
      end else if (!pend) begin
        if (sccb_req) begin
          pend  = 1;
          cnt   = lat;
          s_reg = sccb_reg;
          s_val = sccb_val;
          s_a   = rom_addr;
        end
      end else begin
        if (sccb_req !== 1'b1 || sccb_reg !== s_reg ||
            sccb_val !== s_val || sccb_dev !== 8'h42 ||
            rom_addr !== s_a)
          stab_err++;
        cnt--;
        if (cnt <= 0) begin
          nak = (att[s_a] < nk[s_a]);
          att[s_a]++;
          sccb_done = 1'b1;
          sccb_nack = nak;
          log_q.push_back({5'd0, s_a, s_reg, s_val, 7'd0, nak});
          pend = 0;
        end
      end
    end
  end

  // Expected write attempts from the table contents and NACK budget.
  task automatic model();
    logic [7:0] r, v;
    logic       nak;
    exp_q.delete();
    exp_err  = 0;
    exp_addr = 7;
    for (int a = 0; a < 8; a++) begin
      r = rom[a][15:8];
      v = rom[a][7:0];
      if (r == 8'hFE) begin
        exp_addr = a;
        break;
      end
      if (r != 8'hFF) begin
        for (int k = 0; k <= 3; k++) begin
          nak = (k < nk[a]);
          exp_q.push_back({5'd0, 3'(a), r, v, 7'd0, nak});
          if (!nak) break;
        end
        if (nk[a] > 3) exp_err++;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic kick(input string tag);
    log_q.delete();
    stab_err = 0;
    for (int i = 0; i < 8; i++) att[i] = 0;
    pulse_start();
    chk({tag, "_restart"}, {29'd0, done, busy, cmos_pwdn}, 32'b011);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_fin"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_run(input string tag);
    model();
    chk({tag, "_nwr"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), log_q[i], exp_q[i]);
    chk({tag, "_errcnt"}, {24'd0, err_count}, exp_err);
    chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err != 0});
    chk({tag, "_addr"}, {29'd0, rom_addr}, exp_addr);
    chk({tag, "_pins"}, {29'd0, busy, cmos_pwdn, cmos_rst_n}, 32'b001);
    chk({tag, "_stable"}, stab_err, 0);
  endtask

  task automatic new_run(input string tag);
    kick(tag);
    wait_done(tag);
    check_run(tag);
  endtask

  task automatic dir_rom();
    rom[0] = 16'h1280;
    rom[1] = 16'hFF03;
    rom[2] = 16'h1101;
    rom[3] = 16'hFE00;
    for (int i = 4; i < 8; i++) rom[i] = 16'h3300 + 16'(i);
    for (int i = 0; i < 8; i++) nk[i] = 0;
  endtask

  function automatic int count_reg(input logic [7:0] r);
    int c = 0;
    foreach (log_q[i]) if (log_q[i][23:16] == r) c++;
    return c;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int roll;
    dir_rom();
    lat = 5;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {26'd0, sccb_req, cmos_pwdn, cmos_rst_n,
        busy, done, error}, 32'b010000);
    chk("rst_regs", {5'd0, rom_addr, sccb_reg, sccb_val, err_count}, 0);
    log_q.delete();
    stab_err = 0;
    reset_n = 1'b1;

    n = 0;
    while (cmos_pwdn && n < 200) begin @(negedge clk); n++; end
    chk("pwdn_hold", {31'd0, n inside {[10:11]}}, 1);
    n = 0;
    while (!cmos_rst_n && n < 200) begin @(negedge clk); n++; end
    chk("rstn_hold", {31'd0, n inside {[9:11]}}, 1);
    n = 0;
    while (!sccb_req && n < 200) begin @(negedge clk); n++; end
    chk("pwrup_wait", {31'd0, n inside {[19:23]}}, 1);
    chk("first_wr", {8'd0, sccb_dev, sccb_reg, sccb_val}, 32'h421280);
    n = 0;
    while (!sccb_done && n < 200) begin @(negedge clk); n++; end
    chk("ack_seen", {31'd0, sccb_done}, 1);
    @(negedge clk);
    n = 1;
    while (!sccb_req && n < 200) begin @(negedge clk); n++; end
    // 30-cycle delay entry plus fetch/decode overhead on both sides.
    chk("dly_gap", {31'd0, n inside {[31:36]}}, 1);
    chk("second_wr", {16'd0, sccb_reg, sccb_val}, 32'h1101);
    wait_done("dir");
    check_run("dir");

    dir_rom();
    nk[0] = 9;
    new_run("nack4");
    chk("nack4_pulses", count_reg(8'h12), 4);

    dir_rom();
    nk[0] = 1;
    new_run("nack1");
    chk("nack1_pulses", count_reg(8'h12), 2);

    for (int i = 0; i < 8; i++) begin
      rom[i] = {8'h20 + 8'(i), 8'($urandom_range(0, 255))};
      nk[i]  = 0;
    end
    lat = 2;
    new_run("full");
    repeat (30) @(negedge clk);
    chk("nowrap_addr", {29'd0, rom_addr}, 7);
    chk("nowrap_wr", log_q.size(), 8);
    chk("nowrap_idle", {30'd0, sccb_req, done}, 32'b01);

    dir_rom();
    lat = 5;
    kick("midstart");
    n = 0;
    while (!sccb_req && n < 200) begin @(negedge clk); n++; end
    pulse_start();
    chk("midstart_ign", {28'd0, busy, cmos_pwdn, cmos_rst_n, sccb_req},
        32'b1011);
    wait_done("midstart");
    check_run("midstart");

    dir_rom();
    kick("arst");
    n = 0;
    while (!sccb_req && n < 200) begin @(negedge clk); n++; end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_async", {28'd0, sccb_req, busy, cmos_rst_n, cmos_pwdn},
        32'b0001);
    repeat (2) @(negedge clk);
    log_q.delete();
    stab_err = 0;
    reset_n = 1'b1;
    @(negedge clk);
    wait_done("arst_rerun");
    check_run("arst_rerun");

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 8; i++) begin
        roll = $urandom_range(0, 99);
        if (roll < 8)
          rom[i] = 16'hFE00;
        else if (roll < 22)
          rom[i] = {8'hFF, 8'($urandom_range(0, 3))};
        else
          rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
        nk[i] = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 5);
      end
      lat = $urandom_range(1, 6);
      new_run($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
